// File: rtl/mem_pkg.sv
// Shared definitions for the ping-pong frame buffer: ownership FSM encoding
// and drop-counter sizing.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        PEND = 2'd2
    } pp_state_t;

    localparam int DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

endpackage

// File: rtl/pp_bank_ram.sv
// Simple dual-port RAM holding both frame banks back to back (bank*DEPTH+addr),
// read-first with a registered, non-reset output that holds when not read.
module pp_bank_ram #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 160*140,
    parameter int RAW   = $clog2(2*DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [RAW-1:0]   waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [RAW-1:0]   raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:2*DEPTH-1];
    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            q_reg <= mem[raddr];
        end
    end

    assign rdata = q_reg;

endmodule

// File: rtl/mem_pingpong_bram.sv
// Two-bank frame buffer: the writer streams frames into bank wb, the reader
// random-accesses the completed frame in bank ~wb; banks swap under ownership.
module mem_pingpong_bram
    import mem_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 160*140,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH+1)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_wr,
    input  logic              i_wr_last,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd,
    input  logic [AW-1:0]     i_rd_addr,
    input  logic              i_rd_release,
    output logic [WIDTH-1:0]  o_rd_data,
    output logic              o_rd_valid,
    output logic              o_frame_ready,
    output logic              o_rd_bank_valid,
    output logic [LW-1:0]     o_frame_len,
    output logic              o_wr_bank,
    output logic [DROP_W-1:0] o_drop_cnt
);

    localparam int RAW = $clog2(2*DEPTH);
    localparam logic [AW-1:0]  LAST_ADDR  = AW'(DEPTH-1);
    localparam logic [LW-1:0]  DEPTH_LEN  = LW'(DEPTH);
    localparam logic [RAW-1:0] BANK1_BASE = RAW'(DEPTH);

    pp_state_t         state_reg, state_next;
    logic              wb_reg, wb_next;
    logic [AW-1:0]     wptr_reg, wptr_next;
    logic [LW-1:0]     pend_len_reg, pend_len_next;
    logic [LW-1:0]     frame_len_reg, frame_len_next;
    logic              frame_ready_reg, frame_ready_next;
    logic              rd_bank_valid_reg, rd_bank_valid_next;
    logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic              rd_valid_reg;
    logic              data_seen_reg;

    logic              frame_end;
    logic              swap;
    logic              wr_bank;
    logic              rd_en;
    logic [LW-1:0]     cur_len;
    logic [RAW-1:0]    wr_addr;
    logic [RAW-1:0]    rd_addr;
    logic [WIDTH-1:0]  ram_q;

    // A full bank terminates the frame even without i_wr_last.
    assign frame_end = i_wr && (i_wr_last || (wptr_reg == LAST_ADDR));
    assign cur_len   = LW'(wptr_reg) + LW'(1);
    assign rd_en     = i_rd && (state_reg != IDLE) && (LW'(i_rd_addr) < DEPTH_LEN);

    always_comb begin
        state_next       = state_reg;
        pend_len_next    = pend_len_reg;
        frame_len_next   = frame_len_reg;
        drop_cnt_next    = drop_cnt_reg;
        swap             = 1'b0;
        wr_bank          = wb_reg;
        wptr_next        = wptr_reg;

        if (i_wr) begin
            wptr_next = frame_end ? '0 : wptr_reg + AW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (frame_end) begin
                    swap           = 1'b1;
                    frame_len_next = cur_len;
                    state_next     = READ;
                end
            end
            READ: begin
                if (frame_end && i_rd_release) begin
                    swap           = 1'b1;
                    frame_len_next = cur_len;
                end else if (frame_end) begin
                    pend_len_next = cur_len;
                    state_next    = PEND;
                end else if (i_rd_release) begin
                    state_next = IDLE;
                end
            end
            PEND: begin
                if (i_rd_release) begin
                    // The freed bank becomes the write bank this very cycle.
                    swap           = 1'b1;
                    wr_bank        = ~wb_reg;
                    frame_len_next = pend_len_reg;
                    state_next     = READ;
                    if (frame_end) begin
                        pend_len_next = cur_len;
                        state_next    = PEND;
                    end
                end else if (i_wr) begin
                    if (drop_cnt_reg != DROP_MAX) begin
                        drop_cnt_next = drop_cnt_reg + DROP_W'(1);
                    end
                    state_next = READ;
                    if (frame_end) begin
                        pend_len_next = cur_len;
                        state_next    = PEND;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        wb_next            = swap ? ~wb_reg : wb_reg;
        frame_ready_next   = swap;
        rd_bank_valid_next = (state_next != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg         <= IDLE;
            wb_reg            <= 1'b0;
            wptr_reg          <= '0;
            pend_len_reg      <= '0;
            frame_len_reg     <= '0;
            frame_ready_reg   <= 1'b0;
            rd_bank_valid_reg <= 1'b0;
            drop_cnt_reg      <= '0;
            rd_valid_reg      <= 1'b0;
            data_seen_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            wb_reg            <= wb_next;
            wptr_reg          <= wptr_next;
            pend_len_reg      <= pend_len_next;
            frame_len_reg     <= frame_len_next;
            frame_ready_reg   <= frame_ready_next;
            rd_bank_valid_reg <= rd_bank_valid_next;
            drop_cnt_reg      <= drop_cnt_next;
            rd_valid_reg      <= rd_en;
            data_seen_reg     <= data_seen_reg | rd_en;
        end
    end

    assign wr_addr = wr_bank ? (BANK1_BASE + RAW'(wptr_reg)) : RAW'(wptr_reg);
    assign rd_addr = wb_reg ? RAW'(i_rd_addr) : (BANK1_BASE + RAW'(i_rd_addr));

    pp_bank_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .RAW   (RAW)
    ) u_ram (
        .clk   (i_clk),
        .we    (i_wr),
        .waddr (wr_addr),
        .wdata (i_wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // The RAM register is not reset, so mask it until a read lands after reset.
    assign o_rd_data       = data_seen_reg ? ram_q : '0;
    assign o_rd_valid      = rd_valid_reg;
    assign o_frame_ready   = frame_ready_reg;
    assign o_rd_bank_valid = rd_bank_valid_reg;
    assign o_frame_len     = frame_len_reg;
    assign o_wr_bank       = wb_reg;
    assign o_drop_cnt      = drop_cnt_reg;

endmodule

// File: tb/tb_mem_pingpong_bram.sv
// Directed and randomized checks of the ping-pong frame buffer against a
// frame-level ownership model (DEPTH=16), plus a DEPTH=12 range instance.
module tb_mem_pingpong_bram;

    localparam int W   = 8;
    localparam int D   = 16;
    localparam int AW  = 4;
    localparam int LW  = 5;
    localparam int D2  = 12;
    localparam int LW2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          wr, wr_last, rd, rel;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          rd_valid, frame_ready, rd_bank_valid, wr_bank;
    logic [LW-1:0] frame_len;
    logic [7:0]    drop_cnt;

    logic           d2_wr, d2_last, d2_rd, d2_rel;
    logic [W-1:0]   d2_wdata, d2_rdata;
    logic [AW-1:0]  d2_addr;
    logic           d2_rvalid, d2_ready, d2_rbv, d2_wb;
    logic [LW2-1:0] d2_len;
    logic [7:0]     d2_drop;

    mem_pingpong_bram #(.WIDTH(W), .DEPTH(D), .AW(AW), .LW(LW)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_wr(wr), .i_wr_last(wr_last),
        .i_wr_data(wr_data), .i_rd(rd), .i_rd_addr(rd_addr),
        .i_rd_release(rel), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .o_frame_ready(frame_ready), .o_rd_bank_valid(rd_bank_valid),
        .o_frame_len(frame_len), .o_wr_bank(wr_bank), .o_drop_cnt(drop_cnt)
    );

    mem_pingpong_bram #(.WIDTH(W), .DEPTH(D2), .AW(AW), .LW(LW2)) dut2 (
        .i_clk(clk), .i_rstn(rstn), .i_wr(d2_wr), .i_wr_last(d2_last),
        .i_wr_data(d2_wdata), .i_rd(d2_rd), .i_rd_addr(d2_addr),
        .i_rd_release(d2_rel), .o_rd_data(d2_rdata), .o_rd_valid(d2_rvalid),
        .o_frame_ready(d2_ready), .o_rd_bank_valid(d2_rbv),
        .o_frame_len(d2_len), .o_wr_bank(d2_wb), .o_drop_cnt(d2_drop)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Frame-level model: bank contents, who owns what, and the visible outputs.
    int m_mem [2][D];
    int m_wb, m_wptr, m_owned, m_pending, m_pend_len;
    int m_frame_len, m_ready, m_drop, m_rd_valid, m_rd_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wb = 0; m_wptr = 0; m_owned = 0; m_pending = 0; m_pend_len = 0;
        m_frame_len = 0; m_ready = 0; m_drop = 0; m_rd_valid = 0; m_rd_data = 0;
    endtask

    task automatic model_step(input int w, input int l, input int dat,
                              input int r, input int a, input int rl);
        int fe, tbank, sw, new_len;
        fe = (w != 0) && ((l != 0) || (m_wptr == D-1));
        if ((r != 0) && (m_owned != 0) && (a < D)) begin
            m_rd_valid = 1;
            m_rd_data  = m_mem[1-m_wb][a];
        end else begin
            m_rd_valid = 0;
        end
        if (w != 0) begin
            tbank = ((m_pending != 0) && (rl != 0)) ? 1 - m_wb : m_wb;
            m_mem[tbank][m_wptr] = dat;
        end
        sw = 0;
        new_len = 0;
        if (m_owned == 0) begin
            if (fe) begin sw = 1; new_len = m_wptr + 1; end
        end else if (m_pending == 0) begin
            if (fe && (rl != 0)) begin sw = 1; new_len = m_wptr + 1; end
            else if (fe) begin m_pending = 1; m_pend_len = m_wptr + 1; end
            else if (rl != 0) m_owned = 0;
        end else begin
            if (rl != 0) begin
                sw = 1; new_len = m_pend_len; m_pending = fe;
                if (fe) m_pend_len = m_wptr + 1;
            end else if (w != 0) begin
                if (m_drop < 255) m_drop++;
                m_pending = fe;
                if (fe) m_pend_len = m_wptr + 1;
            end
        end
        m_ready = sw;
        if (sw != 0) begin
            m_wb = 1 - m_wb;
            m_frame_len = new_len;
            m_owned = 1;
        end
        if (w != 0) m_wptr = fe ? 0 : m_wptr + 1;
    endtask

    task automatic check_all(input string t);
        check({t, ".ready"}, 32'(frame_ready), m_ready);
        check({t, ".len"},   32'(frame_len),   m_frame_len);
        check({t, ".wbank"}, 32'(wr_bank),     m_wb);
        check({t, ".rbv"},   32'(rd_bank_valid), m_owned);
        check({t, ".drop"},  32'(drop_cnt),    m_drop);
        check({t, ".rvld"},  32'(rd_valid),    m_rd_valid);
        check({t, ".rdat"},  32'(rd_data),     m_rd_data);
    endtask

    task automatic cycle(input int w, input int l, input int dat,
                         input int r, input int a, input int rl);
        @(negedge clk);
        wr = w[0]; wr_last = l[0]; wr_data = dat[7:0];
        rd = r[0]; rd_addr = a[3:0]; rel = rl[0];
        @(posedge clk);
        model_step(w, l, dat, r, a, rl);
        #1;
        $display("cyc %0d wr=%0d last=%0d din=%02h rd=%0d addr=%0d rel=%0d -> rdy=%0d len=%0d wb=%0d rbv=%0d drop=%0d rv=%0d rdat=%02h",
                 cyc, w, l, dat, r, a, rl, frame_ready, frame_len, wr_bank,
                 rd_bank_valid, drop_cnt, rd_valid, rd_data);
        check_all($sformatf("c%0d", cyc));
        cyc++;
    endtask

    task automatic d2_cycle(input int w, input int dat, input int r, input int a);
        @(negedge clk);
        d2_wr = w[0]; d2_wdata = dat[7:0]; d2_rd = r[0]; d2_addr = a[3:0];
        @(posedge clk);
        #1;
        $display("d2 wr=%0d din=%02h rd=%0d addr=%0d -> rdy=%0d len=%0d wb=%0d rv=%0d rdat=%02h",
                 w, dat, r, a, d2_ready, d2_len, d2_wb, d2_rvalid, d2_rdata);
    endtask

    initial begin
        int w, l, r, a, rl;
        rstn = 1'b0;
        wr = 0; wr_last = 0; wr_data = '0; rd = 0; rd_addr = '0; rel = 0;
        d2_wr = 0; d2_last = 0; d2_rd = 0; d2_rel = 0; d2_wdata = '0; d2_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.d2len", 32'(d2_len), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Frame A: four words, explicit last.
        for (int i = 0; i < 4; i++) cycle(1, (i == 3) ? 1 : 0, 8'hA0 + i, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, i, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Release, then a 16-word frame with forced end; 17th word starts frame B.
        cycle(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cycle(1, 0, 8'h10 + i, 0, 0, 0);
        cycle(1, 0, 8'hC0, 1, 15, 0);
        for (int i = 1; i < 5; i++) cycle(1, (i == 4) ? 1 : 0, 8'hC0 + i, 1, i, 0);

        // Pending frame B dropped by frame C; release exposes C.
        cycle(1, 0, 8'hD0, 0, 0, 0);
        cycle(1, 0, 8'hD1, 0, 0, 0);
        cycle(1, 1, 8'hD2, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, i, 0);

        // Pending frame E; release together with the first word of the next frame.
        cycle(1, 0, 8'hE0, 0, 0, 0);
        cycle(1, 1, 8'hE1, 0, 0, 0);
        cycle(1, 0, 8'hF0, 1, 2, 1);
        cycle(0, 0, 0, 1, 1, 0);
        cycle(1, 1, 8'hF1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0);

        // Reads with no owned frame are ignored.
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 3, 1);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            w  = ($urandom_range(99) < 70) ? 1 : 0;
            l  = (w != 0 && $urandom_range(99) < 15) ? 1 : 0;
            rl = ($urandom_range(99) < 8) ? 1 : 0;
            r  = $urandom_range(1);
            a  = (m_owned != 0) ? $urandom_range(m_frame_len - 1) : $urandom_range(D - 1);
            cycle(w, l, $urandom_range(255), r, a, rl);
        end

        // Asynchronous reset mid-frame and mid-read.
        for (int i = 0; i < 5; i++) cycle(1, (i == 4) ? 1 : 0, 8'h70 + i, 0, 0, 0);
        cycle(1, 0, 8'h80, 1, 0, 0);
        cycle(1, 0, 8'h81, 1, 0, 0);
        @(negedge clk);
        wr = 1; wr_last = 0; wr_data = 8'h82; rd = 1; rd_addr = '0; rel = 0;
        #2 rstn = 1'b0;
        #1;
        model_reset();
        $display("async reset asserted mid-cycle");
        check_all("arst");
        @(negedge clk);
        wr = 0; rd = 0;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1, (i == 2) ? 1 : 0, 8'h90 + i, 0, 0, 0);
        check("arst.newbank", 32'(wr_bank), 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, i, 0);
        check("arst.readback", 32'(rd_data), 8'h92);

        // DEPTH=12 instance: forced end at 12 words and read address range.
        for (int i = 0; i < D2; i++) begin
            d2_cycle(1, 8'h50 + i, 0, 0);
            check($sformatf("d2.ready%0d", i), 32'(d2_ready), (i == D2 - 1) ? 1 : 0);
        end
        check("d2.len", 32'(d2_len), D2);
        check("d2.wb", 32'(d2_wb), 1);
        d2_cycle(0, 0, 1, 11);
        check("d2.rv11", 32'(d2_rvalid), 1);
        check("d2.rd11", 32'(d2_rdata), 8'h5B);
        d2_cycle(0, 0, 1, 12);
        check("d2.rv12", 32'(d2_rvalid), 0);
        check("d2.rd12", 32'(d2_rdata), 8'h5B);
        d2_cycle(0, 0, 1, 15);
        check("d2.rv15", 32'(d2_rvalid), 0);
        check("d2.rd15", 32'(d2_rdata), 8'h5B);
        d2_cycle(0, 0, 1, 3);
        check("d2.rv3", 32'(d2_rvalid), 1);
        check("d2.rd3", 32'(d2_rdata), 8'h53);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
